pipe_sel_mux: RTL



---
 rtl/pipe_sel_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_sel_mux.sv
// Pipelined N-way select stage with valid/ready handshake and a one-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining PIPE_SEL_MUX_SELERR_EN.
module pipe_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
`ifdef PIPE_SEL_MUX_SELERR_EN
  output logic                    sel_err,
`endif
  input  logic                    out_ready
);

  generate
    if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_param_check
      $fatal(1, "pipe_sel_mux: illegal NUM_IN/SEL_W combination");
    end
  endgenerate

  localparam logic [31:0] LAST = 32'(NUM_IN - 1);

  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_valid;
  logic [WIDTH-1:0] sel_word;
  logic [31:0]      sel_ext;
  logic             in_xfer;

  assign sel_ext  = 32'(in_sel);
  assign in_ready = !skid_valid;
  assign in_xfer  = in_valid && in_ready;

  // Any code at or beyond the last index falls through to the last input.
  always_comb begin
    sel_word = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
    for (int unsigned k = 0; k < NUM_IN - 1; k++) begin
      if (sel_ext == 32'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // Skid only fills while main is full, so out_valid is known high here.
      if (out_ready) begin
        out_data   <= skid_data;
        out_sel    <= skid_sel;
        skid_valid <= 1'b0;
      end
    end else if (!out_valid || out_ready) begin
      if (in_xfer) begin
        out_data  <= sel_word;
        out_sel   <= in_sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= sel_word;
      skid_sel   <= in_sel;
      skid_valid <= 1'b1;
    end
  end

`ifdef PIPE_SEL_MUX_SELERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (in_xfer && sel_ext > LAST) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule
